// File: rtl/freq_div_pkg.sv
// Shared types and constants for the runtime-programmable clock divider.
package freq_div_pkg;

    typedef enum logic [1:0] {
        ST_OFF    = 2'd0,
        ST_RUN    = 2'd1,
        ST_SWITCH = 2'd2,
        ST_STOP   = 2'd3
    } state_t;

    localparam int MIN_DIV = 2;

endpackage

// File: rtl/freq_div_duty_shaper.sv
// Builds a 50% duty clk_out from the counter: posedge phase flop plus a
// negedge-delayed copy that stretches the high time by half a cycle for odd divisors.
module freq_div_duty_shaper #(
    parameter int DIV_W = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [DIV_W-1:0] i_cnt,
    input  logic [DIV_W-1:0] i_div,
    input  logic             i_running,
    output logic             o_clk_out
);

    logic r_phase;
    logic r_odd;
    logic r_neg;

    // Inputs are the next-cycle counter/divisor, so r_phase lines up with the registered count.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_phase <= 1'b0;
            r_odd   <= 1'b0;
        end else begin
            r_phase <= i_running && (i_cnt < (i_div >> 1));
            r_odd   <= i_div[0];
        end
    end

    always_ff @(negedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_neg <= 1'b0;
        end else begin
            r_neg <= r_phase & r_odd;
        end
    end

    assign o_clk_out = r_phase | r_neg;

endmodule

// File: rtl/freq_div_ctrl.sv
// Clock-divider controller: sequences start/stop and divisor changes on period
// boundaries so the divided clock never produces a runt or partial period.
module freq_div_ctrl
    import freq_div_pkg::*;
#(
    parameter int DIV_W       = 8,
    parameter int DEFAULT_DIV = 3
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_enable,
    input  logic             i_cfg_valid,
    input  logic [DIV_W-1:0] i_cfg_div,
    output logic             o_cfg_ready,
    output logic             o_cfg_err,
    output logic [DIV_W-1:0] o_cur_div,
    output logic             o_clk_out,
    output logic             o_tick
);

    generate
        if (DEFAULT_DIV < MIN_DIV || DEFAULT_DIV > (2**DIV_W) - 1) begin : g_bad_default
            $error("freq_div_ctrl: DEFAULT_DIV out of legal range");
        end
    endgenerate

    state_t           r_state;
    state_t           w_state_next;
    logic [DIV_W-1:0] r_cnt;
    logic [DIV_W-1:0] w_cnt_next;
    logic [DIV_W-1:0] r_cur_div;
    logic [DIV_W-1:0] w_div_next;
    logic [DIV_W-1:0] r_pend_div;
    logic [DIV_W-1:0] w_pend_next;
    logic             r_pend_vld;
    logic             w_pend_vld_next;
    logic             r_ready_en;
    logic             r_tick;
    logic             r_cfg_err;
    logic             w_wrap;
    logic             w_accept;
    logic             w_cfg_legal;
    logic             w_running_next;
    logic [DIV_W-1:0] w_cnt_inc;

    assign o_cfg_ready    = r_ready_en && (r_state != ST_SWITCH);
    assign w_accept       = i_cfg_valid && o_cfg_ready;
    assign w_cfg_legal    = (i_cfg_div >= DIV_W'(MIN_DIV));
    assign w_wrap         = (r_cnt == (r_cur_div - DIV_W'(1)));
    assign w_cnt_inc      = w_wrap ? '0 : (r_cnt + DIV_W'(1));
    assign w_running_next = (w_state_next != ST_OFF);

    always_comb begin
        w_state_next    = r_state;
        w_cnt_next      = r_cnt;
        w_div_next      = r_cur_div;
        w_pend_next     = r_pend_div;
        w_pend_vld_next = r_pend_vld;
        case (r_state)
            ST_OFF: begin
                w_cnt_next      = '0;
                w_pend_vld_next = 1'b0;
                if (w_accept && w_cfg_legal) begin
                    w_div_next = i_cfg_div;
                end
                if (i_enable) begin
                    w_state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                w_cnt_next = w_cnt_inc;
                if (w_accept && w_cfg_legal) begin
                    w_pend_next     = i_cfg_div;
                    w_pend_vld_next = 1'b1;
                end
                if (!i_enable) begin
                    w_state_next = ST_STOP;
                end else if (w_accept && w_cfg_legal) begin
                    w_state_next = ST_SWITCH;
                end
            end
            ST_SWITCH: begin
                w_cnt_next = w_cnt_inc;
                if (w_wrap) begin
                    w_div_next      = r_pend_div;
                    w_pend_vld_next = 1'b0;
                    w_state_next    = i_enable ? ST_RUN : ST_OFF;
                end
            end
            ST_STOP: begin
                w_cnt_next = w_cnt_inc;
                if (w_accept && w_cfg_legal) begin
                    w_pend_next     = i_cfg_div;
                    w_pend_vld_next = 1'b1;
                end
                // A divisor written while stopping takes effect at the period boundary.
                if (w_wrap && w_pend_vld_next) begin
                    w_div_next      = w_pend_next;
                    w_pend_vld_next = 1'b0;
                    w_state_next    = i_enable ? ST_RUN : ST_OFF;
                end else if (i_enable) begin
                    w_state_next = w_pend_vld_next ? ST_SWITCH : ST_RUN;
                end else if (w_wrap) begin
                    w_state_next = ST_OFF;
                end
            end
            default: begin
                w_state_next = ST_OFF;
                w_cnt_next   = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= ST_OFF;
            r_cnt      <= '0;
            r_cur_div  <= DIV_W'(DEFAULT_DIV);
            r_pend_div <= '0;
            r_pend_vld <= 1'b0;
            r_ready_en <= 1'b0;
            r_tick     <= 1'b0;
            r_cfg_err  <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_cnt      <= w_cnt_next;
            r_cur_div  <= w_div_next;
            r_pend_div <= w_pend_next;
            r_pend_vld <= w_pend_vld_next;
            r_ready_en <= 1'b1;
            r_tick     <= w_running_next && (w_cnt_next == '0);
            r_cfg_err  <= w_accept && !w_cfg_legal;
        end
    end

    freq_div_duty_shaper #(
        .DIV_W (DIV_W)
    ) u_shaper (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_cnt     (w_cnt_next),
        .i_div     (w_div_next),
        .i_running (w_running_next),
        .o_clk_out (o_clk_out)
    );

    assign o_cur_div = r_cur_div;
    assign o_tick    = r_tick;
    assign o_cfg_err = r_cfg_err;

endmodule
